sdram_dq_dir_ctrl: RTL and testbench

SDRAM_DQ_DIR_CTRL -- requirements
Module: sdram_dq_dir_ctrl

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_burst_timer.sv | 26 ++
 rtl/sdram_dq_dir_ctrl.sv | 147 ++++++++++++++
 tb/tb_sdram_dq_dir_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM DQ direction controller: state encodings,
// counter widths and the legal ranges of the timing parameters.
package sdram_pkg;

    localparam int BEAT_W = 3;
    localparam int LAT_W  = 2;
    localparam int CNT_W  = 16;

    localparam int CL_MIN = 1;
    localparam int CL_MAX = 3;
    localparam int BL_MIN = 1;
    localparam int BL_MAX = 8;
    localparam int TA_MIN = 0;
    localparam int TA_MAX = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_TURN    = 3'd4;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sdram_burst_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sdram_burst_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/sdram_dq_dir_ctrl.sv
// SDRAM DQ bus direction controller: sequences write/read bursts, CAS wait
// and read-to-write turnaround, and counts completed bursts.
module sdram_dq_dir_ctrl
    import sdram_pkg::*;
#(
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 4,
    parameter int TURNAROUND  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_write,
    output logic             cmd_ready,
    output logic             dq_oe,
    output logic             wr_data_req,
    output logic             rd_capture,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    // Timers count down to zero, so a phase of N cycles loads N-1.
    localparam int RD_WAIT_LD = (CAS_LATENCY > 1) ? CAS_LATENCY - 2 : 0;
    localparam int TURN_LD    = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;

    localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  WAIT_LOAD = LAT_W'(RD_WAIT_LD);
    localparam logic [LAT_W-1:0]  TURN_LOAD = LAT_W'(TURN_LD);

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic             beat_load;
    logic             beat_done;
    logic             lat_load;
    logic [LAT_W-1:0] lat_val;
    logic             lat_done;
    logic             wr_inc;
    logic             rd_inc;
    logic [CNT_W-1:0] wr_count_reg;
    logic [CNT_W-1:0] rd_count_reg;

    sdram_burst_timer #(.W(BEAT_W)) u_beat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (beat_load),
        .load_val (BEAT_LOAD),
        .done     (beat_done)
    );

    sdram_burst_timer #(.W(LAT_W)) u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (lat_val),
        .done     (lat_done)
    );

    always_comb begin
        state_next = state_reg;
        beat_load  = 1'b0;
        lat_load   = 1'b0;
        lat_val    = WAIT_LOAD;
        wr_inc     = 1'b0;
        rd_inc     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_next = ST_WRITE;
                        beat_load  = 1'b1;
                    end else if (CAS_LATENCY > 1) begin
                        state_next = ST_RD_WAIT;
                        lat_load   = 1'b1;
                        lat_val    = WAIT_LOAD;
                    end else begin
                        state_next = ST_READ;
                        beat_load  = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (beat_done) begin
                    state_next = ST_IDLE;
                    wr_inc     = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (lat_done) begin
                    state_next = ST_READ;
                    beat_load  = 1'b1;
                end
            end
            ST_READ: begin
                if (beat_done) begin
                    rd_inc = 1'b1;
                    if (TURNAROUND > 0) begin
                        state_next = ST_TURN;
                        lat_load   = 1'b1;
                        lat_val    = TURN_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_TURN: begin
                if (lat_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wr_count_reg <= '0;
            rd_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (wr_inc) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end
            if (rd_inc) begin
                rd_count_reg <= rd_count_reg + 1'b1;
            end
        end
    end

    // Outputs decode the state register so reset drops them without a clock.
    assign cmd_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg != ST_IDLE);
    assign dq_oe       = (state_reg == ST_WRITE);
    assign wr_data_req = (state_reg == ST_WRITE);
    assign rd_capture  = (state_reg == ST_READ);
    assign wr_count    = wr_count_reg;
    assign rd_count    = rd_count_reg;

    always @(posedge clk) begin
        assert (in_range(CAS_LATENCY, CL_MIN, CL_MAX));
        assert (in_range(BURST_LEN, BL_MIN, BL_MAX));
        assert (in_range(TURNAROUND, TA_MIN, TA_MAX));
        assert (!(dq_oe && rd_capture));
    end

endmodule

// File: tb/tb_sdram_dq_dir_ctrl.sv
// Directed bench for sdram_dq_dir_ctrl: default-parameter instance plus a
// CL=1/BL=1/TA=0 instance, with a bidirectional DQ delay-wire model.
module tb_sdram_dq_dir_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid, cmd_write;
    logic        cmd_ready, dq_oe, wr_data_req, rd_capture, busy;
    logic [15:0] wr_count, rd_count;

    logic        cmd_valid2, cmd_write2;
    logic        cmd_ready2, dq_oe2, wr_data_req2, rd_capture2, busy2;
    logic [15:0] wr_count2, rd_count2;

    logic [15:0] wr_word;
    logic [15:0] sdram_data;
    logic        sdram_oe;
    wire  [15:0] dq_bus;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic        track_gap  = 1'b0;
    logic        seen_rd    = 1'b0;
    int          last_rd    = 0;
    int          gap        = -1;
    logic        overlap    = 1'b0;
    logic        contention = 1'b0;
    logic [15:0] cap_q[$];

    sdram_dq_dir_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_write   (cmd_write),
        .cmd_ready   (cmd_ready),
        .dq_oe       (dq_oe),
        .wr_data_req (wr_data_req),
        .rd_capture  (rd_capture),
        .busy        (busy),
        .wr_count    (wr_count),
        .rd_count    (rd_count)
    );

    sdram_dq_dir_ctrl #(.CAS_LATENCY(1), .BURST_LEN(1), .TURNAROUND(0)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid2),
        .cmd_write   (cmd_write2),
        .cmd_ready   (cmd_ready2),
        .dq_oe       (dq_oe2),
        .wr_data_req (wr_data_req2),
        .rd_capture  (rd_capture2),
        .busy        (busy2),
        .wr_count    (wr_count2),
        .rd_count    (rd_count2)
    );

    // DQ delay wire: FPGA drives on dq_oe, SDRAM model drives read beats.
    assign #1 dq_bus = dq_oe ? wr_word : (sdram_oe ? sdram_data : 16'hzzzz);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dq_oe && rd_capture) overlap <= 1'b1;
        if (dq_oe && sdram_oe) contention <= 1'b1;
        if (rd_capture) cap_q.push_back(dq_bus);
        if (track_gap && rd_capture) begin
            seen_rd <= 1'b1;
            last_rd <= cyc;
        end
        if (track_gap && seen_rd && dq_oe && gap < 0) gap <= cyc - last_rd - 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;  cmd_write = 1'b0;
        cmd_valid2 = 1'b0; cmd_write2 = 1'b0;
        wr_word = 16'hBEEF;
        sdram_data = 16'h0000;
        sdram_oe = 1'b0;

        #3;
        chk("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_dq_oe", {15'd0, dq_oe}, 16'd0);
        chk("rst_wr_req", {15'd0, wr_data_req}, 16'd0);
        chk("rst_rd_cap", {15'd0, rd_capture}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wr_count", wr_count, 16'd0);
        chk("rst_rd_count", rd_count, 16'd0);

        // Single write accepted at the first edge after reset release.
        tick();
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wr_beat1_oe", {15'd0, dq_oe}, 16'd1);
        chk("wr_beat1_req", {15'd0, wr_data_req}, 16'd1);
        chk("wr_beat1_busy", {15'd0, busy}, 16'd1);
        chk("wr_beat1_ready", {15'd0, cmd_ready}, 16'd0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("wr_beat%0d_oe", k), {15'd0, dq_oe}, 16'd1);
            chk($sformatf("wr_beat%0d_req", k), {15'd0, wr_data_req}, 16'd1);
        end
        tick();
        chk("wr_end_oe", {15'd0, dq_oe}, 16'd0);
        chk("wr_end_ready", {15'd0, cmd_ready}, 16'd1);
        chk("wr_end_count", wr_count, 16'd1);

        // Read: RD_WAIT one cycle, four capture beats, one TURN cycle.
        cmd_valid = 1'b1; cmd_write = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("rd_wait_cap", {15'd0, rd_capture}, 16'd0);
        chk("rd_wait_oe", {15'd0, dq_oe}, 16'd0);
        chk("rd_wait_busy", {15'd0, busy}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rd_beat%0d_cap", k), {15'd0, rd_capture}, 16'd1);
            chk($sformatf("rd_beat%0d_oe", k), {15'd0, dq_oe}, 16'd0);
            sdram_data = 16'hA5A0 + 16'(k);
            sdram_oe = 1'b1;
        end
        tick();
        sdram_oe = 1'b0;
        chk("rd_turn_busy", {15'd0, busy}, 16'd1);
        chk("rd_turn_ready", {15'd0, cmd_ready}, 16'd0);
        chk("rd_turn_cap", {15'd0, rd_capture}, 16'd0);
        chk("rd_turn_count", rd_count, 16'd1);
        tick();
        chk("rd_idle_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rd_cap_size", 16'(cap_q.size()), 16'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_data%0d", k), cap_q[k], 16'hA5A0 + 16'(k));
        end

        // Write, read, write with cmd_valid held high.
        track_gap = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        tick();
        cmd_write = 1'b0;
        chk("alt_w1_oe", {15'd0, dq_oe}, 16'd1);
        repeat (4) tick();
        chk("alt_gap_ready", {15'd0, cmd_ready}, 16'd1);
        tick();
        cmd_write = 1'b1;
        chk("alt_rdwait_busy", {15'd0, busy}, 16'd1);
        chk("alt_rdwait_oe", {15'd0, dq_oe}, 16'd0);
        repeat (6) tick();
        chk("alt_idle_ready", {15'd0, cmd_ready}, 16'd1);
        tick();
        cmd_valid = 1'b0;
        chk("alt_w2_oe", {15'd0, dq_oe}, 16'd1);
        repeat (4) tick();
        track_gap = 1'b0;
        chk("alt_overlap", {15'd0, overlap}, 16'd0);
        chk("alt_contention", {15'd0, contention}, 16'd0);
        chk("alt_gap_cycles", 16'(gap), 16'd2);
        chk("alt_wr_count", wr_count, 16'd3);
        chk("alt_rd_count", rd_count, 16'd2);

        // Reset pulled low in the second write beat.
        cmd_valid = 1'b1; cmd_write = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("abort_beat2_oe", {15'd0, dq_oe}, 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_oe_async", {15'd0, dq_oe}, 16'd0);
        chk("abort_busy_async", {15'd0, busy}, 16'd0);
        chk("abort_ready_async", {15'd0, cmd_ready}, 16'd1);
        chk("abort_wr_count", wr_count, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_post_count", wr_count, 16'd0);
        chk("abort_post_busy", {15'd0, busy}, 16'd0);

        // Counter wrap from 0xFFFF.
        force dut.wr_count_reg = 16'hFFFF;
        #1 release dut.wr_count_reg;
        chk("wrap_preload", wr_count, 16'hFFFF);
        cmd_valid = 1'b1; cmd_write = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("wrap_wr_count", wr_count, 16'h0000);
        chk("wrap_rd_count", rd_count, 16'h0000);

        // CL=1, BL=1, TA=0 instance.
        cmd_valid2 = 1'b1; cmd_write2 = 1'b0;
        tick();
        cmd_valid2 = 1'b0;
        chk("cl1_cap", {15'd0, rd_capture2}, 16'd1);
        chk("cl1_ready_busy", {15'd0, cmd_ready2}, 16'd0);
        chk("cl1_oe", {15'd0, dq_oe2}, 16'd0);
        tick();
        chk("cl1_ready_after", {15'd0, cmd_ready2}, 16'd1);
        chk("cl1_cap_after", {15'd0, rd_capture2}, 16'd0);
        chk("cl1_rd_count", rd_count2, 16'd1);
        cmd_valid2 = 1'b1; cmd_write2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        chk("bl1_wr_oe", {15'd0, dq_oe2}, 16'd1);
        chk("bl1_wr_req", {15'd0, wr_data_req2}, 16'd1);
        tick();
        chk("bl1_wr_done_oe", {15'd0, dq_oe2}, 16'd0);
        chk("bl1_wr_count", wr_count2, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
